clock_ctrl: RTL and testbench

- Button-driven sequencer for the `clock` timekeeping block.
- Converts debounced single-cycle button pulses into edit sessions for the time-of-day and the alarm. Drives the clock's `start`, `set_hours`/`set_mins`/`set_secs` load strobes and its alarm value ports.
- Owns the armed alarm and the buzzer ring/snooze/timeout policy, using the clock's running time as its seconds reference.

---
 rtl/clock_ctrl_if.sv | 44 ++++
 rtl/clock_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_clock_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_if.sv
// Button, running-time and control signals between the clock_ctrl
// sequencer and its surroundings (button debouncers, clock core, display).
interface clock_ctrl_if;
  logic       btn_mode;
  logic       btn_next;
  logic       btn_inc;
  logic       btn_snooze;
  logic [4:0] cur_hours;
  logic [5:0] cur_mins;
  logic [5:0] cur_secs;
  logic       start;
  logic       set_hours;
  logic       set_mins;
  logic       set_secs;
  logic [4:0] load_hours;
  logic [5:0] load_mins;
  logic [5:0] load_secs;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_mins;
  logic [5:0] alarm_secs;
  logic       alarm_armed;
  logic       buzzer_en;
  logic [2:0] edit_state;

  // Environment side: drives buttons and the running time, observes controls
  modport master (
    output btn_mode, btn_next, btn_inc, btn_snooze,
    output cur_hours, cur_mins, cur_secs,
    input  start, set_hours, set_mins, set_secs,
    input  load_hours, load_mins, load_secs,
    input  alarm_hours, alarm_mins, alarm_secs,
    input  alarm_armed, buzzer_en, edit_state
  );

  // Sequencer side
  modport slave (
    input  btn_mode, btn_next, btn_inc, btn_snooze,
    input  cur_hours, cur_mins, cur_secs,
    output start, set_hours, set_mins, set_secs,
    output load_hours, load_mins, load_secs,
    output alarm_hours, alarm_mins, alarm_secs,
    output alarm_armed, buzzer_en, edit_state
  );
endinterface

// File: rtl/clock_ctrl.sv
// Button-driven sequencer for the clock block: time-of-day and alarm edit
// sessions, load strobes to the clock, and the alarm ring/snooze policy.
module clock_ctrl #(
  parameter int BUZZ_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        reset,
  clock_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    RUN = 3'd0, TH = 3'd1, TM = 3'd2, TS = 3'd3, AH = 3'd4, AM = 3'd5, AS = 3'd6
  } edit_t;
  typedef enum logic [1:0] {A_IDLE = 2'd0, A_RING = 2'd1, A_SNOOZE = 2'd2} alarm_t;

  localparam logic [CNT_W-1:0] BUZZ_LAST   = CNT_W'(BUZZ_SECS - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

  edit_t            state, state_nxt;
  alarm_t           astate, astate_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       ed_hours, al_hours;
  logic [5:0]       ed_mins, ed_secs, al_mins, al_secs;
  logic             armed, start_q, strobe_q, match_q;
  logic [5:0]       secs_q;

  logic do_mode, do_next, do_inc, do_snooze;
  logic capture, recall, commit_time, commit_alarm, disarm, dismiss;
  logic match, trigger, sec_tick;

  function automatic logic [4:0] inc_hours(input logic [4:0] h);
    return (h >= 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_sixty(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  // One button acts per cycle: mode > next > inc > snooze
  assign do_mode   = bus.btn_mode;
  assign do_next   = bus.btn_next & ~bus.btn_mode;
  assign do_inc    = bus.btn_inc & ~bus.btn_mode & ~bus.btn_next;
  assign do_snooze = bus.btn_snooze & ~bus.btn_mode & ~bus.btn_next & ~bus.btn_inc;

  // match_q makes the trigger edge-sensitive so a stalled clock rings once
  assign match    = armed && (state == RUN) &&
                    ({bus.cur_hours, bus.cur_mins, bus.cur_secs} == {al_hours, al_mins, al_secs});
  assign trigger  = match && !match_q;
  assign sec_tick = (bus.cur_secs != secs_q);

  // Edit FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // Edit FSM next state and action decode
  always_comb begin
    state_nxt    = state;
    capture      = 1'b0;
    recall       = 1'b0;
    commit_time  = 1'b0;
    commit_alarm = 1'b0;
    disarm       = 1'b0;
    dismiss      = 1'b0;
    case (state)
      RUN: if (do_mode) begin
        if (astate == A_IDLE) begin
          capture   = 1'b1;
          state_nxt = TH;
        end else begin
          dismiss = 1'b1;
        end
      end
      TH, TM: if (do_mode) begin
        recall    = 1'b1;
        state_nxt = AH;
      end else if (do_next) begin
        state_nxt = (state == TH) ? TM : TS;
      end
      TS: if (do_mode) begin
        recall    = 1'b1;
        state_nxt = AH;
      end else if (do_next) begin
        commit_time = 1'b1;
        state_nxt   = RUN;
      end
      AH, AM: if (do_mode) begin
        disarm    = 1'b1;
        state_nxt = RUN;
      end else if (do_next) begin
        state_nxt = (state == AH) ? AM : AS;
      end
      AS: if (do_mode) begin
        disarm    = 1'b1;
        state_nxt = RUN;
      end else if (do_next) begin
        commit_alarm = 1'b1;
        state_nxt    = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Alarm FSM state and ring/snooze second counter
  always_ff @(posedge clk) begin
    if (reset) begin
      astate <= A_IDLE;
      cnt    <= '0;
    end else begin
      astate <= astate_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Alarm FSM: dismiss beats snooze beats the second count
  always_comb begin
    astate_nxt = astate;
    cnt_nxt    = cnt;
    case (astate)
      A_IDLE: if (trigger) begin
        astate_nxt = A_RING;
        cnt_nxt    = '0;
      end
      A_RING: if (dismiss) begin
        astate_nxt = A_IDLE;
      end else if (do_snooze) begin
        astate_nxt = A_SNOOZE;
        cnt_nxt    = '0;
      end else if (sec_tick) begin
        if (cnt == BUZZ_LAST) begin
          astate_nxt = A_IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      A_SNOOZE: if (dismiss) begin
        astate_nxt = A_IDLE;
      end else if (sec_tick) begin
        cnt_nxt = '0;
        if (cnt == SNOOZE_LAST) astate_nxt = A_RING;
        else                    cnt_nxt    = cnt + CNT_W'(1);
      end
      default: astate_nxt = A_IDLE;
    endcase
  end

  // Edit registers: capture running time, recall the alarm, or bump the active field
  always_ff @(posedge clk) begin
    if (reset) begin
      ed_hours <= '0;
      ed_mins  <= '0;
      ed_secs  <= '0;
    end else if (capture) begin
      ed_hours <= bus.cur_hours;
      ed_mins  <= bus.cur_mins;
      ed_secs  <= bus.cur_secs;
    end else if (recall) begin
      ed_hours <= al_hours;
      ed_mins  <= al_mins;
      ed_secs  <= al_secs;
    end else if (do_inc) begin
      case (state)
        TH, AH:  ed_hours <= inc_hours(ed_hours);
        TM, AM:  ed_mins  <= inc_sixty(ed_mins);
        TS, AS:  ed_secs  <= inc_sixty(ed_secs);
        default: ;
      endcase
    end
  end

  // Committed alarm value and armed flag; alarm value survives a disarm
  always_ff @(posedge clk) begin
    if (reset) begin
      al_hours <= '0;
      al_mins  <= '0;
      al_secs  <= '0;
      armed    <= 1'b0;
    end else if (commit_alarm) begin
      al_hours <= ed_hours;
      al_mins  <= ed_mins;
      al_secs  <= ed_secs;
      armed    <= 1'b1;
    end else if (disarm) begin
      armed <= 1'b0;
    end
  end

  // Registered run enable, load strobe and edge-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q  <= 1'b0;
      strobe_q <= 1'b0;
      secs_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      start_q  <= (state_nxt == RUN);
      strobe_q <= commit_time;
      secs_q   <= bus.cur_secs;
      match_q  <= match;
    end
  end

  assign bus.start       = start_q;
  assign bus.set_hours   = strobe_q;
  assign bus.set_mins    = strobe_q;
  assign bus.set_secs    = strobe_q;
  assign bus.load_hours  = ed_hours;
  assign bus.load_mins   = ed_mins;
  assign bus.load_secs   = ed_secs;
  assign bus.alarm_hours = al_hours;
  assign bus.alarm_mins  = al_mins;
  assign bus.alarm_secs  = al_secs;
  assign bus.alarm_armed = armed;
  assign bus.buzzer_en   = (astate == A_RING);
  assign bus.edit_state  = state;
endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios with literal
// expectations, then randomized buttons/time against a behavioural model.
module tb_clock_ctrl;
  localparam int BUZZ   = 3;
  localparam int SNOOZE = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  clock_ctrl_if bus();

  clock_ctrl #(.BUZZ_SECS(BUZZ), .SNOOZE_SECS(SNOOZE), .CNT_W(9)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: editing 0=none 1=time 2=alarm, field 0..2 = h/m/s;
  // ring 0=quiet 1=ringing 2=snoozed, left = seconds remaining in that phase.
  int m_edit, m_field, m_ring, m_left, m_prev_s;
  int m_val[3];
  int m_al[3];
  int cur_v[3];
  int lim[3] = '{24, 60, 60};
  bit m_armed, m_prev_match, m_strobe, m_start, m_in_reset;
  bit mvalid = 1'b0;
  bit pm, pn, pi, ps, tick, match, rise, active;

  always @(posedge clk) begin
    if (reset) begin
      m_edit = 0; m_field = 0; m_ring = 0; m_left = 0; m_prev_s = 0;
      m_val = '{0, 0, 0};
      m_al  = '{0, 0, 0};
      m_armed = 0; m_prev_match = 0; m_strobe = 0; m_start = 0;
      m_in_reset = 1; mvalid = 1;
    end else begin
      m_in_reset = 0;
      cur_v = '{int'(bus.cur_hours), int'(bus.cur_mins), int'(bus.cur_secs)};
      pm = bus.btn_mode;
      pn = bus.btn_next && !bus.btn_mode;
      pi = bus.btn_inc && !bus.btn_mode && !bus.btn_next;
      ps = bus.btn_snooze && !bus.btn_mode && !bus.btn_next && !bus.btn_inc;
      tick  = (cur_v[2] != m_prev_s);
      match = m_armed && (m_edit == 0) &&
              (cur_v[0] == m_al[0]) && (cur_v[1] == m_al[1]) && (cur_v[2] == m_al[2]);
      rise   = match && !m_prev_match;
      active = (m_ring != 0);
      m_prev_s     = cur_v[2];
      m_prev_match = match;
      m_strobe     = 0;
      // alarm policy
      if (m_ring == 0) begin
        if (rise) begin m_ring = 1; m_left = BUZZ; end
      end else if (m_edit == 0 && pm) begin
        m_ring = 0;
      end else if (m_ring == 1 && ps) begin
        m_ring = 2; m_left = SNOOZE;
      end else if (tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_ring == 1) m_ring = 0;
          else begin m_ring = 1; m_left = BUZZ; end
        end
      end
      // edit sessions
      if (m_edit == 0) begin
        if (pm && !active) begin m_edit = 1; m_field = 0; m_val = cur_v; end
      end else if (pm) begin
        if (m_edit == 1) begin m_edit = 2; m_field = 0; m_val = m_al; end
        else begin m_edit = 0; m_armed = 0; end
      end else if (pn) begin
        if (m_field < 2) m_field++;
        else begin
          if (m_edit == 1) m_strobe = 1;
          else begin m_al = m_val; m_armed = 1; end
          m_edit = 0;
        end
      end else if (pi) begin
        m_val[m_field] = (m_val[m_field] >= lim[m_field] - 1) ? 0 : m_val[m_field] + 1;
      end
      m_start = (m_edit == 0);
    end
  end

  // Compare every cycle once the model has seen a reset edge
  always @(negedge clk) begin
    if (mvalid) begin
      chk("start", int'(bus.start), int'(m_start));
      chk("set_hours", int'(bus.set_hours), int'(m_strobe));
      chk("set_mins", int'(bus.set_mins), int'(m_strobe));
      chk("set_secs", int'(bus.set_secs), int'(m_strobe));
      if (m_strobe || m_in_reset) begin
        chk("load_hours", int'(bus.load_hours), m_val[0]);
        chk("load_mins", int'(bus.load_mins), m_val[1]);
        chk("load_secs", int'(bus.load_secs), m_val[2]);
      end
      chk("alarm_hours", int'(bus.alarm_hours), m_al[0]);
      chk("alarm_mins", int'(bus.alarm_mins), m_al[1]);
      chk("alarm_secs", int'(bus.alarm_secs), m_al[2]);
      chk("alarm_armed", int'(bus.alarm_armed), int'(m_armed));
      chk("buzzer_en", int'(bus.buzzer_en), int'(m_ring == 1));
      chk("edit_state", int'(bus.edit_state),
          (m_edit == 0) ? 0 : ((m_edit == 1) ? 1 : 4) + m_field);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit n, input bit i, input bit s);
    bus.btn_mode = m; bus.btn_next = n; bus.btn_inc = i; bus.btn_snooze = s;
    cyc();
    bus.btn_mode = 0; bus.btn_next = 0; bus.btn_inc = 0; bus.btn_snooze = 0;
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hours = 5'(h);
    bus.cur_mins  = 6'(m);
    bus.cur_secs  = 6'(s);
  endtask

  task automatic sec_adv();
    bus.cur_secs = (bus.cur_secs >= 6'd59) ? 6'd0 : bus.cur_secs + 6'd1;
    cyc();
  endtask

  task automatic chk_load(input string tag, input int h, input int m, input int s);
    chk({tag, "_strobe"}, int'(bus.set_hours), 1);
    chk({tag, "_h"}, int'(bus.load_hours), h);
    chk({tag, "_m"}, int'(bus.load_mins), m);
    chk({tag, "_s"}, int'(bus.load_secs), s);
  endtask

  initial begin
    bus.btn_mode = 0; bus.btn_next = 0; bus.btn_inc = 0; bus.btn_snooze = 0;
    set_cur(0, 0, 0);
    reset = 1;
    // reset behaviour
    cyc();
    chk("rst_start", int'(bus.start), 0);
    chk("rst_state", int'(bus.edit_state), 0);
    chk("rst_buzz", int'(bus.buzzer_en), 0);
    cyc();
    chk("rst_start2", int'(bus.start), 0);
    chk("rst_armed", int'(bus.alarm_armed), 0);
    reset = 0;
    cyc();
    chk("start_after_rst", int'(bus.start), 1);

    // time set: 01:02:03 -> hours+2, secs+60 -> 03:02:03
    set_cur(1, 2, 3); cyc();
    press(1, 0, 0, 0);
    chk("edit_th", int'(bus.edit_state), 1);
    chk("start_in_edit", int'(bus.start), 0);
    repeat (2) press(0, 0, 1, 0);
    press(0, 1, 0, 0); press(0, 1, 0, 0);
    chk("edit_ts", int'(bus.edit_state), 3);
    repeat (60) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    chk_load("tset", 3, 2, 3);
    chk("tset_start", int'(bus.start), 1);
    chk("model_tset_h", m_val[0], 3);
    cyc();
    chk("strobe_once", int'(bus.set_hours), 0);

    // wrap of every field, and an out-of-range captured hour
    set_cur(23, 59, 59); cyc();
    press(1, 0, 0, 0); press(0, 0, 1, 0); press(0, 1, 0, 0);
    press(0, 0, 1, 0); press(0, 1, 0, 0); press(0, 0, 1, 0); press(0, 1, 0, 0);
    chk_load("wrap", 0, 0, 0);
    set_cur(31, 10, 10); cyc();
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
    chk_load("wrap31", 0, 10, 10);

    // alarm set to 01:03:02, then disarm, then re-arm from the recalled value
    set_cur(5, 0, 0); cyc();
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    chk("edit_ah", int'(bus.edit_state), 4);
    press(0, 0, 1, 0); press(0, 1, 0, 0);
    repeat (3) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    repeat (2) press(0, 0, 1, 0);
    press(0, 1, 0, 0);
    chk("al_h", int'(bus.alarm_hours), 1);
    chk("al_m", int'(bus.alarm_mins), 3);
    chk("al_s", int'(bus.alarm_secs), 2);
    chk("al_armed", int'(bus.alarm_armed), 1);
    chk("al_no_strobe", int'(bus.set_hours), 0);
    chk("model_al_m", m_al[1], 3);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    chk("disarm", int'(bus.alarm_armed), 0);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 1, 0, 0); press(0, 1, 0, 0); press(0, 1, 0, 0);
    chk("rearm", int'(bus.alarm_armed), 1);
    chk("rearm_s", int'(bus.alarm_secs), 2);

    // ring, snooze after one tick, re-ring, auto-off
    set_cur(1, 3, 1); cyc(); cyc();
    chk("pre_ring", int'(bus.buzzer_en), 0);
    set_cur(1, 3, 2); cyc();
    chk("ring_on", int'(bus.buzzer_en), 1);
    sec_adv();
    press(0, 0, 0, 1);
    chk("snoozed", int'(bus.buzzer_en), 0);
    repeat (4) sec_adv();
    chk("snooze_4", int'(bus.buzzer_en), 0);
    sec_adv();
    chk("rering", int'(bus.buzzer_en), 1);
    repeat (2) sec_adv();
    chk("ring_2", int'(bus.buzzer_en), 1);
    sec_adv();
    chk("auto_off", int'(bus.buzzer_en), 0);

    // mode + snooze together dismisses; stalled matching second does not retrigger
    set_cur(1, 3, 2); cyc();
    chk("ring_again", int'(bus.buzzer_en), 1);
    press(1, 0, 0, 1);
    chk("dismiss", int'(bus.buzzer_en), 0);
    chk("dismiss_run", int'(bus.edit_state), 0);
    chk("dismiss_armed", int'(bus.alarm_armed), 1);
    repeat (3) cyc();
    chk("no_retrigger", int'(bus.buzzer_en), 0);

    // match while editing does not ring
    set_cur(1, 3, 0); cyc();
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    chk("edit_tm", int'(bus.edit_state), 2);
    set_cur(1, 3, 2); repeat (3) cyc();
    chk("edit_no_ring", int'(bus.buzzer_en), 0);
    set_cur(2, 0, 0); cyc();
    press(0, 1, 0, 0); press(0, 1, 0, 0);
    cyc();
    chk("edit_done_quiet", int'(bus.buzzer_en), 0);

    // reset during ring
    set_cur(1, 3, 1); cyc();
    set_cur(1, 3, 2); cyc();
    chk("ring_pre_rst", int'(bus.buzzer_en), 1);
    reset = 1; cyc();
    chk("rst_ring_buzz", int'(bus.buzzer_en), 0);
    chk("rst_ring_armed", int'(bus.alarm_armed), 0);
    chk("rst_ring_alh", int'(bus.alarm_hours), 0);
    reset = 0; cyc();

    // randomized phase
    for (int k = 0; k < 4000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (m_armed && r < 3) set_cur(m_al[0], m_al[1], m_al[2]);
      else if (r < 4) set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
      else if (r < 35) bus.cur_secs = (bus.cur_secs >= 6'd59) ? 6'd0 : bus.cur_secs + 6'd1;
      bus.btn_mode   = ($urandom_range(0, 99) < 4);
      bus.btn_next   = ($urandom_range(0, 99) < 8);
      bus.btn_inc    = ($urandom_range(0, 99) < 8);
      bus.btn_snooze = ($urandom_range(0, 99) < 5);
      reset          = ($urandom_range(0, 599) == 0);
      cyc();
    end
    bus.btn_mode = 0; bus.btn_next = 0; bus.btn_inc = 0; bus.btn_snooze = 0;
    reset = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
